// File: rtl/demux_1_to_n_response_cache_pkg.sv
// demux_1_to_n_response_cache_pkg: response beat types, route decode and dispatch states
package demux_1_to_n_response_cache_pkg;
    localparam int ROUTE_ID_WIDTH   = 8;
    localparam int DATA_WIDTH       = 32;
    localparam int DROP_COUNT_WIDTH = 16;

    typedef struct packed {
        logic [ROUTE_ID_WIDTH-1:0] route_id;
        logic [DATA_WIDTH-1:0]     data;
    } MemoryPacketResponsePayload;

    typedef struct packed {
        logic                       valid;
        MemoryPacketResponsePayload payload;
    } MemoryPacketResponse;

    typedef struct packed {
        logic empty;
        logic prog_full;
    } FIFOStateSignalsOutput;

    typedef struct packed {
        logic rd_en;
    } FIFOStateSignalsInput;

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } dispatch_state_e;

    function automatic logic [ROUTE_ID_WIDTH-1:0] get_response_route_id(input MemoryPacketResponsePayload p);
        return p.route_id;
    endfunction

    // Saturating add so a flood of bad beats cannot wrap the counter back to a small value
    function automatic logic [DROP_COUNT_WIDTH-1:0] drop_count_add(input logic [DROP_COUNT_WIDTH-1:0] c,
                                                                   input logic [1:0] inc);
        logic [DROP_COUNT_WIDTH:0] s;
        s = {1'b0, c} + (DROP_COUNT_WIDTH+1)'(inc);
        return s[DROP_COUNT_WIDTH] ? '1 : s[DROP_COUNT_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/demux_1_to_n_response_cache_egress_lane.sv
// demux_1_to_n_response_cache_egress_lane: per-requestor FIFO with registered response output
module demux_1_to_n_response_cache_egress_lane
    import demux_1_to_n_response_cache_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int PROG_THRESH = 24
) (
    input  logic                       ap_clk,
    input  logic                       rst,
    input  logic                       push,
    input  MemoryPacketResponsePayload din,
    input  FIFOStateSignalsInput       signals_in,
    output logic                       prog_full,
    output logic                       rst_busy,
    output MemoryPacketResponse        response_out
);
    MemoryPacketResponsePayload dout;
    logic valid, full, empty, wr_busy, rd_busy;

    xpm_fifo_sync_wrapper #(
        .DEPTH      (DEPTH),
        .WIDTH      ($bits(MemoryPacketResponsePayload)),
        .PROG_THRESH(PROG_THRESH)
    ) u_fifo (
        .clk        (ap_clk),
        .rst        (rst),
        .wr_en      (push & ~full),
        .din        (din),
        .rd_en      (signals_in.rd_en & ~empty),
        .dout       (dout),
        .valid      (valid),
        .full       (full),
        .empty      (empty),
        .prog_full  (prog_full),
        .wr_rst_busy(wr_busy),
        .rd_rst_busy(rd_busy)
    );

    assign rst_busy = wr_busy | rd_busy;

    always_ff @(posedge ap_clk or posedge rst)
        if (rst) response_out <= '0;
        else response_out <= {valid, dout};
endmodule

// File: rtl/xpm_fifo_sync_wrapper.sv
// xpm_fifo_sync_wrapper: single-clock FIFO, read latency 1, with a short post-reset busy window
module xpm_fifo_sync_wrapper #(
    parameter int DEPTH       = 32,
    parameter int WIDTH       = 8,
    parameter int PROG_THRESH = 16,
    parameter int BUSY_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full,
    output logic             empty,
    output logic             prog_full,
    output logic             wr_rst_busy,
    output logic             rd_rst_busy
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [2:0]       busy_cnt;
    logic             busy, do_wr, do_rd;

    assign busy        = busy_cnt != 3'd0;
    assign full        = count == (AW+1)'(DEPTH);
    assign empty       = count == '0;
    assign prog_full   = count >= (AW+1)'(PROG_THRESH);
    assign wr_rst_busy = busy;
    assign rd_rst_busy = busy;
    assign do_wr       = wr_en & ~full & ~busy;
    assign do_rd       = rd_en & ~empty & ~busy;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            busy_cnt <= 3'(BUSY_CYCLES);
        end else begin
            busy_cnt <= busy_cnt - {2'b00, busy};
            wr_ptr   <= wr_ptr + AW'(do_wr);
            rd_ptr   <= rd_ptr + AW'(do_rd);
            count    <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
            valid    <= do_rd;
        end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
        if (do_rd) dout <= mem[rd_ptr];
    end
endmodule

// File: rtl/demux_1_to_n_response_cache.sv
// demux_1_to_n_response_cache: buffers cache response beats and routes each to its requestor lane
module demux_1_to_n_response_cache
    import demux_1_to_n_response_cache_pkg::*;
#(
    parameter int NUM_MEMORY_RECEIVER = 2,
    parameter int ID_WIDTH            = (NUM_MEMORY_RECEIVER > 1) ? $clog2(NUM_MEMORY_RECEIVER) : 1,
    parameter int FIFO_INGRESS_DEPTH  = 32,
    parameter int INGRESS_PROG_THRESH = 16,
    parameter int FIFO_EGRESS_DEPTH   = 32,
    parameter int EGRESS_PROG_THRESH  = 24
) (
    input  logic                        ap_clk,
    input  logic                        areset_n,
    input  MemoryPacketResponse         response_in,
    output FIFOStateSignalsOutput       fifo_response_signals_out,
    input  FIFOStateSignalsInput        fifo_response_signals_in [NUM_MEMORY_RECEIVER],
    output MemoryPacketResponse         response_out [NUM_MEMORY_RECEIVER],
    output logic                        fifo_setup_signal,
    output logic                        route_error_out,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count_out
);
    localparam int N = NUM_MEMORY_RECEIVER;

    logic                       rst_ctrl, rst_fifo, rst_disp;
    MemoryPacketResponse        in_q;
    MemoryPacketResponsePayload ing_dout, hold_payload;
    logic                       ing_wr, ing_rd, ing_valid, ing_full, ing_empty, ing_pf, ing_wbusy, ing_rbusy;
    logic [N-1:0]               eg_push, eg_pf, eg_busy;
    logic                       hold_valid, rd_inflight, id_ok, cur_pf, hold_push, hold_drop, any_busy, ovf;
    logic [ROUTE_ID_WIDTH-1:0]  hold_id;
    logic [ID_WIDTH-1:0]        lane;
    dispatch_state_e            state, state_next;

    // Reset is asserted asynchronously but released on a clock edge, one copy per area
    always_ff @(posedge ap_clk or negedge areset_n)
        if (!areset_n) {rst_ctrl, rst_fifo, rst_disp} <= 3'b111;
        else {rst_ctrl, rst_fifo, rst_disp} <= 3'b000;

    assign ing_wr = in_q.valid & ~ing_full;
    assign ovf    = in_q.valid & ing_full;

    xpm_fifo_sync_wrapper #(
        .DEPTH      (FIFO_INGRESS_DEPTH),
        .WIDTH      ($bits(MemoryPacketResponsePayload)),
        .PROG_THRESH(INGRESS_PROG_THRESH)
    ) u_ingress (
        .clk        (ap_clk),
        .rst        (rst_fifo),
        .wr_en      (ing_wr),
        .din        (in_q.payload),
        .rd_en      (ing_rd),
        .dout       (ing_dout),
        .valid      (ing_valid),
        .full       (ing_full),
        .empty      (ing_empty),
        .prog_full  (ing_pf),
        .wr_rst_busy(ing_wbusy),
        .rd_rst_busy(ing_rbusy)
    );

    assign hold_id   = get_response_route_id(hold_payload);
    assign lane      = hold_id[ID_WIDTH-1:0];
    assign id_ok     = 32'(hold_id) < 32'(N);
    assign cur_pf    = id_ok & eg_pf[lane];
    assign hold_push = hold_valid & id_ok & ~cur_pf;
    assign hold_drop = hold_valid & ~id_ok;
    assign any_busy  = ing_wbusy | ing_rbusy | (|eg_busy);
    // One read in flight at a time keeps the hold register from ever being overwritten
    assign ing_rd    = (state == RUN) & ~ing_empty & ~rd_inflight & (~hold_valid | hold_push | hold_drop);

    always_comb
        state_next = (state == SETUP) ? (any_busy ? SETUP : RUN) :
                     (hold_valid & cur_pf) ? STALL : RUN;

    always_ff @(posedge ap_clk or posedge rst_disp)
        if (rst_disp) begin
            state        <= SETUP;
            hold_valid   <= 1'b0;
            hold_payload <= '0;
            rd_inflight  <= 1'b0;
        end else begin
            state        <= state_next;
            hold_valid   <= ing_valid | (hold_valid & ~hold_push & ~hold_drop);
            hold_payload <= ing_valid ? ing_dout : hold_payload;
            rd_inflight  <= ing_rd;
        end

    always_ff @(posedge ap_clk or posedge rst_ctrl)
        if (rst_ctrl) begin
            in_q                      <= '0;
            fifo_response_signals_out <= 2'b10;
            fifo_setup_signal         <= 1'b1;
            route_error_out           <= 1'b0;
            drop_count_out            <= '0;
        end else begin
            in_q                      <= response_in;
            fifo_response_signals_out <= {ing_empty, ing_pf};
            fifo_setup_signal         <= state == SETUP;
            route_error_out           <= route_error_out | hold_drop;
            drop_count_out            <= drop_count_add(drop_count_out, {1'b0, ovf} + {1'b0, hold_drop});
        end

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign eg_push[i] = hold_push & (lane == ID_WIDTH'(i));
        demux_1_to_n_response_cache_egress_lane #(
            .DEPTH      (FIFO_EGRESS_DEPTH),
            .PROG_THRESH(EGRESS_PROG_THRESH)
        ) u_lane (
            .ap_clk      (ap_clk),
            .rst         (rst_fifo),
            .push        (eg_push[i]),
            .din         (hold_payload),
            .signals_in  (fifo_response_signals_in[i]),
            .prog_full   (eg_pf[i]),
            .rst_busy    (eg_busy[i]),
            .response_out(response_out[i])
        );
    end
endmodule

// File: tb/tb_demux_1_to_n_response_cache.sv
// tb_demux_1_to_n_response_cache: directed checks of routing, latency, back-pressure, drops and reset
module tb_demux_1_to_n_response_cache;
    import demux_1_to_n_response_cache_pkg::*;

    logic                        ap_clk = 1'b0;
    logic                        areset_n;
    MemoryPacketResponse         response_in;
    FIFOStateSignalsOutput       sig_out;
    FIFOStateSignalsInput        sig_in [4];
    MemoryPacketResponse         response_out [4];
    logic                        fifo_setup_signal, route_error_out;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_out;

    int n_checks = 0;
    int n_fail = 0;
    logic rand_rd = 1'b0;
    MemoryPacketResponsePayload got [4][$];
    int base [4];
    logic [7:0] lat_ids [4] = '{8'd3, 8'd0, 8'd2, 8'd1};

    demux_1_to_n_response_cache #(.NUM_MEMORY_RECEIVER(4)) dut (
        .ap_clk                   (ap_clk),
        .areset_n                 (areset_n),
        .response_in              (response_in),
        .fifo_response_signals_out(sig_out),
        .fifo_response_signals_in (sig_in),
        .response_out             (response_out),
        .fifo_setup_signal        (fifo_setup_signal),
        .route_error_out          (route_error_out),
        .drop_count_out           (drop_count_out)
    );

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk)
        for (int l = 0; l < 4; l++)
            if (response_out[l].valid) got[l].push_back(response_out[l].payload);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (rand_rd)
            for (int l = 0; l < 4; l++) sig_in[l].rd_en = 1'($urandom_range(0, 1));
        @(negedge ap_clk);
    endtask

    task automatic set_rd(input logic [3:0] m);
        for (int l = 0; l < 4; l++) sig_in[l].rd_en = m[l];
    endtask

    task automatic mark();
        for (int l = 0; l < 4; l++) base[l] = got[l].size();
    endtask

    function automatic int cnt(input int l);
        return got[l].size() - base[l];
    endfunction

    task automatic send(input logic [7:0] id, input logic [31:0] d);
        int w;
        w = 0;
        while (sig_out.prog_full && w < 400) begin
            tick();
            w++;
        end
        if (w >= 400) check("send_prog_full_timeout", 64'(w), 0);
        response_in = {1'b1, id, d};
        tick();
        response_in = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int lat, id, n_sent, w;
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, id, n_sent, w;
        areset_n    = 1'b0;
        response_in = '0;
        set_rd(4'b0000);
        repeat (10) @(negedge ap_clk);
        check("rst_setup", fifo_setup_signal, 1);
        check("rst_fifo_state", sig_out, 2'b10);
        check("rst_route_error", route_error_out, 0);
        check("rst_drop_count", drop_count_out, 0);
        for (int l = 0; l < 4; l++) check("rst_valid", response_out[l].valid, 0);
        areset_n = 1'b1;
        tick();
        check("setup_held_after_release", fifo_setup_signal, 1);
        w = 0;
        while (fifo_setup_signal && w < 50) begin
            tick();
            w++;
        end
        check("setup_falls", fifo_setup_signal, 0);
        idle(2);

        // single beats to ids 3,0,2,1, measuring the latency of each
        set_rd(4'b1111);
        mark();
        for (int k = 0; k < 4; k++) begin
            id = int'(lat_ids[k]);
            response_in = {1'b1, lat_ids[k], 32'hA0 + 32'(id)};
            lat = 0;
            tick();
            response_in = '0;
            while (!response_out[id].valid && lat < 20) begin
                tick();
                lat++;
            end
            check("latency", 64'(lat), 6);
            idle(4);
        end
        for (int l = 0; l < 4; l++) begin
            check("single_count", 64'(cnt(l)), 1);
            if (cnt(l) == 1) begin
                check("single_data", got[l][base[l]].data, 32'hA0 + 32'(l));
                check("single_route_id", got[l][base[l]].route_id, 8'(l));
            end
        end

        // out-of-range id between two good beats
        mark();
        send(8'd0, 32'h100);
        send(8'd5, 32'h105);
        send(8'd1, 32'h101);
        idle(30);
        check("err_lane0_count", 64'(cnt(0)), 1);
        check("err_lane1_count", 64'(cnt(1)), 1);
        check("err_lane2_count", 64'(cnt(2)), 0);
        check("err_lane3_count", 64'(cnt(3)), 0);
        if (cnt(0) == 1) check("err_lane0_data", got[0][base[0]].data, 32'h100);
        if (cnt(1) == 1) check("err_lane1_data", got[1][base[1]].data, 32'h101);
        check("route_error", route_error_out, 1);
        check("drop_count_one", drop_count_out, 1);

        // stalled lane 1: behave as the cache and stop on ingress prog_full
        mark();
        set_rd(4'b1101);
        n_sent = 0;
        for (int k = 0; k < 60; k++) begin
            w = 0;
            while (sig_out.prog_full && w < 40) begin
                tick();
                w++;
            end
            if (sig_out.prog_full) break;
            response_in = {1'b1, 8'd1, 32'h300 + 32'(k)};
            tick();
            response_in = '0;
            n_sent++;
        end
        check("stall_ingress_prog_full", sig_out.prog_full, 1);
        check("stall_enough_sent", 64'(n_sent >= 41), 1);
        check("stall_lane1_silent", 64'(cnt(1)), 0);
        set_rd(4'b1111);
        for (int k = n_sent; k < 60; k++) send(8'd1, 32'h300 + 32'(k));
        w = 0;
        while (cnt(1) < 60 && w < 600) begin
            tick();
            w++;
        end
        idle(10);
        check("stall_lane1_count", 64'(cnt(1)), 60);
        for (int j = 0; j < 60 && j < cnt(1); j++) check("stall_order", got[1][base[1] + j].data, 32'h300 + 32'(j));
        check("stall_other_lanes", 64'(cnt(0) + cnt(2) + cnt(3)), 0);
        check("stall_no_drop", drop_count_out, 1);

        // 64 round-robin beats, random rd_en
        mark();
        rand_rd = 1'b1;
        for (int k = 0; k < 64; k++) send(8'(k % 4), 32'h400 + 32'(k));
        rand_rd = 1'b0;
        set_rd(4'b1111);
        w = 0;
        while ((cnt(0) + cnt(1) + cnt(2) + cnt(3)) < 64 && w < 600) begin
            tick();
            w++;
        end
        idle(10);
        for (int l = 0; l < 4; l++) begin
            check("rr_count", 64'(cnt(l)), 16);
            for (int j = 0; j < 16 && j < cnt(l); j++)
                check("rr_order", got[l][base[l] + j].data, 32'h400 + 32'(4 * j + l));
        end
        check("rr_no_drop", drop_count_out, 1);

        // reset with beats queued in egress
        set_rd(4'b0000);
        for (int k = 0; k < 10; k++) send(8'(k % 4), 32'h500 + 32'(k));
        idle(40);
        mark();
        areset_n = 1'b0;
        #1;
        check("midrst_setup", fifo_setup_signal, 1);
        check("midrst_fifo_state", sig_out, 2'b10);
        check("midrst_route_error", route_error_out, 0);
        check("midrst_drop_count", drop_count_out, 0);
        for (int l = 0; l < 4; l++) check("midrst_valid", response_out[l].valid, 0);
        idle(5);
        set_rd(4'b1111);
        areset_n = 1'b1;
        idle(80);
        for (int l = 0; l < 4; l++) check("midrst_nothing_emitted", 64'(cnt(l)), 0);
        check("midrst_setup_done", fifo_setup_signal, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
